icache_axi_fill: RTL

//  Parametrised direct-mapped instruction cache with an AXI4 read-burst refill master.

---
 rtl/icache_axi_fill_pkg.sv | 32 +++
 rtl/icache_axi_fill_line_store.sv | 44 ++++
 rtl/icache_axi_fill.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_fill_pkg.sv
// ----------------------------------------------------------------------------
// icache_axi_fill_pkg
//   Shared definitions for the instruction-cache refill block:
//     - AXI encodings used by the read-burst master (INCR burst, OKAY response)
//     - refill FSM state encoding
//     - ic_log2: ceiling log2 for deriving address-field widths from the
//       cache geometry parameters
// ----------------------------------------------------------------------------
package icache_axi_fill_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_AR   = 2'd1,
        IC_R    = 2'd2
    } ic_state_e;

    // Ceiling log2, usable in constant expressions (parameter widths).
    function automatic int ic_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/icache_axi_fill_line_store.sv
// ----------------------------------------------------------------------------
// icache_axi_fill_line_store
//   Instruction data array of the direct-mapped cache:
//   NUM_LINES * LINE_WORDS words of DATA_WIDTH bits.
//   Ports:
//     clk_i                 clock for the write port
//     we_i                  write enable (one refill beat)
//     wline_i / wword_i     line index and word-within-line being written
//     wdata_i               beat data
//     rline_i / rword_i     asynchronous read address (fetch path)
//     rdata_o               word at (rline_i, rword_i), combinational
// ----------------------------------------------------------------------------
module icache_axi_fill_line_store
    import icache_axi_fill_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 64
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [ic_log2(NUM_LINES)-1:0]  wline_i,
    input  logic [ic_log2(LINE_WORDS)-1:0] wword_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [ic_log2(NUM_LINES)-1:0]  rline_i,
    input  logic [ic_log2(LINE_WORDS)-1:0] rword_i,
    output logic [DATA_WIDTH-1:0]          rdata_o
);

    localparam int DEPTH = NUM_LINES * LINE_WORDS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // {line, word} concatenation is the flat word address; both fields are
    // powers of two so the array is densely packed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wline_i, wword_i}] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[{rline_i, rword_i}];

endmodule

// File: rtl/icache_axi_fill.sv
// ----------------------------------------------------------------------------
// icache_axi_fill
//   Direct-mapped instruction cache with an AXI4 read-burst refill master.
//   Hits return data with zero wait states; a miss fetches the whole line as
//   one INCR burst of LINE_WORDS beats.
//   Ports:
//     m00_axi_aclk / m00_axi_aresetn   clock, async active-low reset
//     fetch_addr                       processor fetch byte address
//     fetch_data / miss                instruction word, stall flag (comb.)
//     inv                              pulse: invalidate whole cache
//     bus_err                          pulse: a refill ended with an error
//     m00_axi_ar*                      AXI read-address channel (master)
//     m00_axi_r* / m00_axi_rready      AXI read-data channel
//   Geometry: NUM_LINES and LINE_WORDS are powers of two, NUM_LINES >= 2.
// ----------------------------------------------------------------------------
module icache_axi_fill
    import icache_axi_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 64,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  miss,
    input  logic                  inv,
    output logic                  bus_err,
    output logic [ID_WIDTH-1:0]   m00_axi_arid,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic                  m00_axi_arlock,
    output logic [3:0]            m00_axi_arcache,
    output logic [2:0]            m00_axi_arprot,
    output logic [3:0]            m00_axi_arqos,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [ID_WIDTH-1:0]   m00_axi_rid,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam int OFF_W  = ic_log2(DATA_WIDTH / 8);
    localparam int WORD_W = ic_log2(LINE_WORDS);
    localparam int IDX_W  = ic_log2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - WORD_W - IDX_W;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    // ---------------------------------------------------------------- decode
    logic [TAG_W-1:0]  f_tag;
    logic [IDX_W-1:0]  f_idx;
    logic [WORD_W-1:0] f_word;

    assign f_word = fetch_addr[OFF_W +: WORD_W];
    assign f_idx  = fetch_addr[OFF_W + WORD_W +: IDX_W];
    assign f_tag  = fetch_addr[ADDR_WIDTH-1 -: TAG_W];

    // Byte offset and rid carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{m00_axi_rid, fetch_addr[OFF_W-1:0]};

    // ----------------------------------------------------------- state regs
    ic_state_e             state_q, state_d;
    logic [TAG_W-1:0]      tag_q, tag_d;       // latched line being filled
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_W-1:0]     cnt_q, cnt_d;       // beat counter
    logic                  err_q, err_d;       // sticky error for this burst
    logic                  inv_pend_q, inv_pend_d;
    logic                  bus_err_q, bus_err_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_ram_q [NUM_LINES];
    logic                  tag_we;

    logic                  hit;
    logic                  beat;
    logic                  final_beat;
    logic                  beat_err;
    logic                  fill_err;

    // Hits are only reported in IDLE: during a fill the data array of the
    // victim line is being overwritten while its old tag may still be valid.
    assign hit = valid_q[f_idx] && (tag_ram_q[f_idx] == f_tag) && (state_q == IC_IDLE);

    assign beat       = (state_q == IC_R) && m00_axi_rvalid;
    assign final_beat = beat && (cnt_q == LAST_WORD);
    assign beat_err   = (m00_axi_rresp != AXI_RESP_OKAY) ||
                        (m00_axi_rlast != (cnt_q == LAST_WORD));
    assign fill_err   = err_q || beat_err;

    // --------------------------------------------------- FSM: state register
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q <= IC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------- FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IC_IDLE: if (!hit)            state_d = IC_AR;
            IC_AR:   if (m00_axi_arready) state_d = IC_R;
            IC_R:    if (final_beat)      state_d = IC_IDLE;
            default:                      state_d = IC_IDLE;
        endcase
    end

    // ----------------------------------------------------- FSM: output logic
    always_comb begin
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        unique case (state_q)
            IC_AR:   m00_axi_arvalid = 1'b1;
            IC_R:    m00_axi_rready  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------ fill bookkeeping logic
    always_comb begin
        tag_d      = tag_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        inv_pend_d = inv_pend_q;
        valid_d    = valid_q;
        bus_err_d  = 1'b0;
        tag_we     = 1'b0;

        if (state_q == IC_IDLE) begin
            if (!hit) begin
                tag_d = f_tag;
                idx_d = f_idx;
            end
            if (inv) begin
                valid_d = '0;
            end
        end else if (inv) begin
            inv_pend_d = 1'b1;
        end

        if (beat) begin
            cnt_d = cnt_q + WORD_W'(1);
            err_d = fill_err;
            if (cnt_q == LAST_WORD) begin
                cnt_d      = '0;
                err_d      = 1'b0;
                inv_pend_d = 1'b0;
                bus_err_d  = fill_err;
                // A pending or coincident invalidate beats validation.
                if (inv_pend_q || inv) begin
                    valid_d = '0;
                end else if (fill_err) begin
                    valid_d[idx_q] = 1'b0;
                end else begin
                    valid_d[idx_q] = 1'b1;
                    tag_we         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            inv_pend_q <= 1'b0;
            bus_err_q  <= 1'b0;
            valid_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            inv_pend_q <= inv_pend_d;
            bus_err_q  <= bus_err_d;
            valid_q    <= valid_d;
        end
    end

    // Latched line address and tag array need no reset: they are only
    // consulted behind the FSM and the valid bits.
    always_ff @(posedge m00_axi_aclk) begin
        tag_q <= tag_d;
        idx_q <= idx_d;
        if (tag_we) begin
            tag_ram_q[idx_q] <= tag_q;
        end
    end

    // ------------------------------------------------------------ data array
    icache_axi_fill_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_line_store (
        .clk_i   (m00_axi_aclk),
        .we_i    (beat),
        .wline_i (idx_q),
        .wword_i (cnt_q),
        .wdata_i (m00_axi_rdata),
        .rline_i (f_idx),
        .rword_i (f_word),
        .rdata_o (fetch_data)
    );

    // --------------------------------------------------------------- outputs
    assign miss    = !hit;
    assign bus_err = bus_err_q;

    assign m00_axi_arid    = '0;
    assign m00_axi_araddr  = {tag_q, idx_q, {(WORD_W + OFF_W){1'b0}}};
    assign m00_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m00_axi_arsize  = 3'(OFF_W);
    assign m00_axi_arburst = AXI_BURST_INCR;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = 4'b0000;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;

endmodule
